plane_scheduler: RTL and testbench

PLANE_SCHEDULER -- requirements
Module: plane_scheduler

---
 rtl/plane_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_plane_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plane_scheduler.sv
// Plane scheduler: walks one pixel job across NZ wall planes through a shared
// validity checker, keeps the first (lowest-plane) hit, and hands back a result.
module plane_scheduler #(
    parameter int NZ  = 8,
    parameter int LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [9:0]          start_p,
    input  logic [5*NZ-1:0]     wall_bank,
    output logic                chk_go,
    output logic [4:0]          chk_wall,
    output logic [2:0]          chk_plane,
    output logic [9:0]          chk_p,
    input  logic                chk_en,
    input  logic signed [9:0]   chk_x,
    input  logic signed [9:0]   chk_y,
    input  logic signed [9:0]   chk_z,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_hit,
    output logic [9:0]          res_p,
    output logic [2:0]          res_plane,
    output logic signed [9:0]   res_x,
    output logic signed [9:0]   res_y,
    output logic signed [9:0]   res_z
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESULT
    } state_t;

    localparam logic [2:0] LAST_PLANE = 3'(NZ - 1);

    state_t                 r_state;
    state_t                 w_state_next;

    logic [5*NZ-1:0]        r_bank;
    logic                   r_chk_go;
    logic [4:0]             r_chk_wall;
    logic [2:0]             r_chk_plane;
    logic [9:0]             r_chk_p;

    // In-flight tags: entry LAT-1 is the issue whose response is due this cycle.
    logic [LAT-1:0]         r_if_vld;
    logic [2:0]             r_if_tag [LAT];

    logic                   r_res_hit;
    logic [9:0]             r_res_p;
    logic [2:0]             r_res_plane;
    logic signed [9:0]      r_res_x;
    logic signed [9:0]      r_res_y;
    logic signed [9:0]      r_res_z;

    logic                   w_accept;
    logic                   w_due;
    logic                   w_cap;
    logic                   w_older;
    logic                   w_issue_next;
    logic [2:0]             w_next_plane;
    logic [4:0]             w_next_wall;

    assign w_accept     = (r_state == S_IDLE) && start_valid;
    assign w_due        = r_if_vld[LAT-1];
    // Only the first qualified hit of a job is kept; res_hit doubles as the "already hit" flag.
    assign w_cap        = w_due && chk_en && !r_res_hit &&
                          ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_issue_next = (r_state == S_ISSUE) && !w_cap && (r_chk_plane != LAST_PLANE);
    assign w_next_plane = r_chk_plane + 3'd1;

    // w_older: responses still outstanding behind the one due this cycle.
    generate
        if (LAT > 1) begin : g_older
            assign w_older = |r_if_vld[LAT-2:0];
        end else begin : g_no_older
            assign w_older = 1'b0;
        end
    endgenerate

    // Select the latched wall mask of the next plane (never past NZ-1).
    always_comb begin
        w_next_wall = 5'd0;
        for (int k = 0; k < NZ; k++) begin
            if (w_next_plane == 3'(k)) begin
                w_next_wall = r_bank[5*k +: 5];
            end
        end
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_cap) begin
                    w_state_next = (r_chk_go || w_older) ? S_DRAIN : S_RESULT;
                end else if (r_chk_plane == LAST_PLANE) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_older) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue port: job latch on accept, then one plane per cycle until hit or last plane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank      <= '0;
            r_chk_go    <= 1'b0;
            r_chk_wall  <= 5'd0;
            r_chk_plane <= 3'd0;
            r_chk_p     <= 10'd0;
        end else if (w_accept) begin
            r_bank      <= wall_bank;
            r_chk_go    <= 1'b1;
            r_chk_wall  <= wall_bank[4:0];
            r_chk_plane <= 3'd0;
            r_chk_p     <= start_p;
        end else if (w_issue_next) begin
            r_chk_go    <= 1'b1;
            r_chk_wall  <= w_next_wall;
            r_chk_plane <= w_next_plane;
        end else begin
            r_chk_go    <= 1'b0;
        end
    end

    // In-flight shift register: each stage ages the plane tag of one issue by a cycle.
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_inflight
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_if_vld[0] <= 1'b0;
                        r_if_tag[0] <= 3'd0;
                    end else begin
                        r_if_vld[0] <= r_chk_go;
                        r_if_tag[0] <= r_chk_plane;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_if_vld[gi] <= 1'b0;
                        r_if_tag[gi] <= 3'd0;
                    end else begin
                        r_if_vld[gi] <= r_if_vld[gi-1];
                        r_if_tag[gi] <= r_if_tag[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Result registers: defaults on job accept, overwritten once by the first hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_hit   <= 1'b0;
            r_res_p     <= 10'd0;
            r_res_plane <= 3'd0;
            r_res_x     <= 10'h3FF;
            r_res_y     <= 10'h3FF;
            r_res_z     <= 10'h3FF;
        end else if (w_accept) begin
            r_res_hit   <= 1'b0;
            r_res_p     <= start_p;
            r_res_plane <= 3'd0;
            r_res_x     <= 10'h3FF;
            r_res_y     <= 10'h3FF;
            r_res_z     <= 10'h3FF;
        end else if (w_cap) begin
            r_res_hit   <= 1'b1;
            r_res_plane <= r_if_tag[LAT-1];
            r_res_x     <= chk_x;
            r_res_y     <= chk_y;
            r_res_z     <= chk_z;
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_RESULT);
    assign chk_go      = r_chk_go;
    assign chk_wall    = r_chk_wall;
    assign chk_plane   = r_chk_plane;
    assign chk_p       = r_chk_p;
    assign res_hit     = r_res_hit;
    assign res_p       = r_res_p;
    assign res_plane   = r_res_plane;
    assign res_x       = r_res_x;
    assign res_y       = r_res_y;
    assign res_z       = r_res_z;

endmodule

// File: tb/tb_plane_scheduler.sv
// Bench for plane_scheduler: two instances (LAT=1 and LAT=3) run the same jobs in
// lockstep against a checker model and a first-hit reference model.
module tb_plane_scheduler;

    localparam int NZ = 8;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start_valid;
    logic              res_ready;
    logic [9:0]        start_p;
    logic [5*NZ-1:0]   wall_bank;

    logic              start_ready_w [NI];
    logic              chk_go_w      [NI];
    logic [4:0]        chk_wall_w    [NI];
    logic [2:0]        chk_plane_w   [NI];
    logic [9:0]        chk_p_w       [NI];
    logic              chk_en_w      [NI];
    logic signed [9:0] chk_x_w       [NI];
    logic signed [9:0] chk_y_w       [NI];
    logic signed [9:0] chk_z_w       [NI];
    logic              res_valid_w   [NI];
    logic              res_hit_w     [NI];
    logic [9:0]        res_p_w       [NI];
    logic [2:0]        res_plane_w   [NI];
    logic signed [9:0] res_x_w       [NI];
    logic signed [9:0] res_y_w       [NI];
    logic signed [9:0] res_z_w       [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            plane_scheduler #(
                .NZ  (NZ),
                .LAT ((gi == 0) ? 1 : 3)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start_valid (start_valid),
                .start_ready (start_ready_w[gi]),
                .start_p     (start_p),
                .wall_bank   (wall_bank),
                .chk_go      (chk_go_w[gi]),
                .chk_wall    (chk_wall_w[gi]),
                .chk_plane   (chk_plane_w[gi]),
                .chk_p       (chk_p_w[gi]),
                .chk_en      (chk_en_w[gi]),
                .chk_x       (chk_x_w[gi]),
                .chk_y       (chk_y_w[gi]),
                .chk_z       (chk_z_w[gi]),
                .res_valid   (res_valid_w[gi]),
                .res_ready   (res_ready),
                .res_hit     (res_hit_w[gi]),
                .res_p       (res_p_w[gi]),
                .res_plane   (res_plane_w[gi]),
                .res_x       (res_x_w[gi]),
                .res_y       (res_y_w[gi]),
                .res_z       (res_z_w[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d]: got %0h, expected %0h", tag, lat_of(inst), got, exp);
        end
    endtask

    // Current job and the checker's per-plane answers.
    logic [9:0]        job_p;
    logic [7:0]        job_hm;
    logic [5*NZ-1:0]   job_bank;
    logic signed [9:0] tx [NZ];
    logic signed [9:0] ty [NZ];
    logic signed [9:0] tz [NZ];

    // Reference expectations.
    logic              exp_hit;
    logic [2:0]        exp_plane;
    logic signed [9:0] exp_x, exp_y, exp_z;
    int                exp_issues  [NI];
    int                exp_res_cyc [NI];

    // First-hit model: lowest hit plane wins; issue runs until its response lands.
    task automatic model();
        int h;
        int iss;
        h = -1;
        for (int k = 0; k < NZ; k++) begin
            if (job_hm[k] && h < 0) h = k;
        end
        exp_hit   = (h >= 0);
        exp_plane = 3'd0;
        exp_x     = 10'h3FF;
        exp_y     = 10'h3FF;
        exp_z     = 10'h3FF;
        if (h >= 0) begin
            exp_plane = 3'(h);
            exp_x     = tx[h];
            exp_y     = ty[h];
            exp_z     = tz[h];
        end
        for (int i = 0; i < NI; i++) begin
            iss = (h < 0) ? NZ : h + 1 + lat_of(i);
            if (iss > NZ) iss = NZ;
            exp_issues[i]  = iss;
            exp_res_cyc[i] = iss + lat_of(i) + 1;
        end
    endtask

    task automatic new_job(input logic [9:0] p, input logic [7:0] hm);
        job_p    = p;
        job_hm   = hm;
        job_bank = 40'({$urandom(), $urandom()});
        for (int k = 0; k < NZ; k++) begin
            tx[k] = 10'($urandom());
            ty[k] = 10'($urandom());
            tz[k] = 10'($urandom());
        end
        model();
    endtask

    // Checker model: answers each issue exactly LAT cycles later, junk otherwise.
    int   gcyc = 0;
    int   due_cyc [NI][16] = '{default: -1};
    logic [2:0] due_pl [NI][16];
    bit   force_en = 1'b0;

    always @(posedge clk) gcyc <= gcyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (chk_go_w[i]) begin
                due_cyc[i][(gcyc + lat_of(i)) % 16] = gcyc + lat_of(i);
                due_pl[i][(gcyc + lat_of(i)) % 16]  = chk_plane_w[i];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (!force_en && due_cyc[i][gcyc % 16] == gcyc) begin
                chk_en_w[i] = job_hm[due_pl[i][gcyc % 16]];
                chk_x_w[i]  = tx[due_pl[i][gcyc % 16]];
                chk_y_w[i]  = ty[due_pl[i][gcyc % 16]];
                chk_z_w[i]  = tz[due_pl[i][gcyc % 16]];
            end else begin
                chk_en_w[i] = force_en ? 1'b1 : 1'($urandom_range(0, 1));
                chk_x_w[i]  = 10'($urandom());
                chk_y_w[i]  = 10'($urandom());
                chk_z_w[i]  = 10'($urandom());
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            chk_en_w[i] = 1'b0;
            chk_x_w[i]  = 10'd0;
            chk_y_w[i]  = 10'd0;
            chk_z_w[i]  = 10'd0;
        end
    end

    // Monitor: per-instance cycle count from accept, issue sequence and result checks.
    int cyc   [NI];
    int n_iss [NI];
    bit armed [NI] = '{default: 1'b0};
    bit done  [NI] = '{default: 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                armed[i] = 1'b0;
                done[i]  = 1'b0;
            end else begin
                if (armed[i] && done[i] && !res_valid_w[i]) begin
                    chk("ready_after_consume", i, 32'(start_ready_w[i]), 32'd1);
                    armed[i] = 1'b0;
                end
                if (armed[i]) begin
                    cyc[i]++;
                    if (chk_go_w[i]) begin
                        chk("go_within_count", i, 32'(n_iss[i] < exp_issues[i]), 32'd1);
                        chk("go_cycle", i, 32'(cyc[i]), 32'(n_iss[i] + 1));
                        chk("chk_plane", i, 32'(chk_plane_w[i]), 32'(n_iss[i]));
                        chk("chk_p", i, 32'(chk_p_w[i]), 32'(job_p));
                        if (n_iss[i] < NZ) begin
                            chk("chk_wall", i, 32'(chk_wall_w[i]), 32'(job_bank[5*n_iss[i] +: 5]));
                        end
                        n_iss[i]++;
                    end
                    if (res_valid_w[i]) begin
                        if (!done[i]) begin
                            chk("res_cycle", i, 32'(cyc[i]), 32'(exp_res_cyc[i]));
                            chk("issue_count", i, 32'(n_iss[i]), 32'(exp_issues[i]));
                            done[i] = 1'b1;
                        end
                        chk("res_hit", i, 32'(res_hit_w[i]), 32'(exp_hit));
                        chk("res_plane", i, 32'(res_plane_w[i]), 32'(exp_plane));
                        chk("res_p", i, 32'(res_p_w[i]), 32'(job_p));
                        chk("res_x", i, 32'(res_x_w[i]), 32'(exp_x));
                        chk("res_y", i, 32'(res_y_w[i]), 32'(exp_y));
                        chk("res_z", i, 32'(res_z_w[i]), 32'(exp_z));
                        chk("ready_in_result", i, 32'(start_ready_w[i]), 32'd0);
                    end
                end
                if (start_valid && start_ready_w[i]) begin
                    armed[i] = 1'b1;
                    done[i]  = 1'b0;
                    cyc[i]   = 0;
                    n_iss[i] = 0;
                end
            end
        end
    end

    // Offer the job, scramble inputs after accept, wait for both results, consume.
    task automatic run_job(input int hold, input bit keep_valid);
        bit ok;
        start_p     = job_p;
        wall_bank   = job_bank;
        start_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = start_ready_w[0] && start_ready_w[1];
        end
        chk("accept_timeout", 0, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        start_valid = keep_valid;
        start_p     = 10'($urandom());
        wall_bank   = 40'({$urandom(), $urandom()});
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = done[0] && done[1];
        end
        chk("result_timeout", 0, 32'(ok), 32'd1);
        repeat (hold) @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_start_ready"}, i, 32'(start_ready_w[i]), 32'd1);
            chk({tag, "_chk_go"}, i, 32'(chk_go_w[i]), 32'd0);
            chk({tag, "_chk_plane"}, i, 32'(chk_plane_w[i]), 32'd0);
            chk({tag, "_chk_wall"}, i, 32'(chk_wall_w[i]), 32'd0);
            chk({tag, "_chk_p"}, i, 32'(chk_p_w[i]), 32'd0);
            chk({tag, "_res_valid"}, i, 32'(res_valid_w[i]), 32'd0);
            chk({tag, "_res_hit"}, i, 32'(res_hit_w[i]), 32'd0);
            chk({tag, "_res_p"}, i, 32'(res_p_w[i]), 32'd0);
            chk({tag, "_res_x"}, i, 32'($unsigned(res_x_w[i])), 32'h3FF);
            chk({tag, "_res_z"}, i, 32'($unsigned(res_z_w[i])), 32'h3FF);
        end
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        start_p     = 10'd0;
        wall_bank   = '0;
        job_hm      = 8'd0;
        for (int k = 0; k < NZ; k++) begin
            tx[k] = 10'd0;
            ty[k] = 10'd0;
            tz[k] = 10'd0;
        end
        repeat (2) @(negedge clk);
        reset_check("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No hit at all.
        new_job(10'd37, 8'b0000_0000);
        run_job(0, 1'b0);
        // Single hit on plane 2 with fixed coordinates.
        new_job(10'($urandom()), 8'b0000_0100);
        tx[2] = 10'sd5;
        ty[2] = 10'sd12;
        tz[2] = 10'sd128;
        model();
        run_job(1, 1'b0);
        // Hits on planes 4 and 6: first wins.
        new_job(10'($urandom()), 8'b0101_0000);
        run_job(0, 1'b0);
        // Hit on the last plane, result held 5 cycles with start_valid high.
        new_job(10'($urandom()), 8'b1000_0000);
        run_job(5, 1'b1);
        // Hit on plane 0 (LAT=3 instance drains three responses).
        new_job(10'($urandom()), 8'b1111_1111);
        run_job(0, 1'b0);

        // Reset in the middle of issue.
        new_job(10'($urandom()), 8'b0000_0000);
        start_p     = job_p;
        wall_bank   = job_bank;
        start_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            seen = chk_go_w[0] && (chk_plane_w[0] == 3'd3);
            if (start_ready_w[0]) start_valid = 1'b1;
            else start_valid = 1'b0;
        end
        chk("plane3_timeout", 0, 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        start_valid = 1'b0;
        #1 reset_check("async_rst");
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        force_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("stray_res_valid", i, 32'(res_valid_w[i]), 32'd0);
                chk("stray_chk_go", i, 32'(chk_go_w[i]), 32'd0);
                chk("stray_start_ready", i, 32'(start_ready_w[i]), 32'd1);
            end
        end
        @(posedge clk);
        #1 force_en = 1'b0;

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            logic [7:0] hm;
            hm = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom() & $urandom());
            new_job(10'($urandom()), hm);
            run_job($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        start_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
